decoder_4_16_stream: RTL and testbench

- Registered, flow-controlled 4-to-16 binary-to-one-hot decoder.
- It is the inverse companion of the team's 16-to-4 encoder.
- It sits between a producer of 4-bit indices and a consumer of 16-bit one-hot select vectors.
- A 2-entry output buffer gives full throughput with a registered in_ready, and a saturating counter tracks decoded transfers.

---
 rtl/decoder_4_16_stream_if.sv | 33 +++
 rtl/decoder_4_16_stream.sv | 133 +++++++++++++
 tb/tb_decoder_4_16_stream.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_4_16_stream_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decoder_4_16_stream_if : index-in / one-hot-out stream bundle    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface decoder_4_16_stream_if #(
   parameter int IDX_W = 4,
   parameter int CNT_W = 16
) ();
   localparam int OUT_W = 2**IDX_W;

   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_index;
   logic             in_enable;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_onehot;
   logic [CNT_W-1:0] out_count;
   logic             clr_count;

   // slave is the decoder itself; master is the producer/consumer side
   modport slave (
      input  in_valid, in_index, in_enable, out_ready, clr_count,
      output in_ready, out_valid, out_onehot, out_count
   );

   modport master (
      output in_valid, in_index, in_enable, out_ready, clr_count,
      input  in_ready, out_valid, out_onehot, out_count
   );
endinterface
`default_nettype wire

// File: rtl/decoder_4_16_stream.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decoder_4_16_stream : registered 4-to-16 one-hot decoder with a  |
// | 2-entry output buffer and saturating transfer counter            |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module decoder_4_16_stream #(
   parameter int IDX_W          = 4,
   parameter int CNT_W          = 16,
   parameter bit ZERO_MAPS_BIT0 = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   decoder_4_16_stream_if.slave  bus
);
   localparam int OUT_W = 2**IDX_W;
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [OUT_W-1:0]  r_head;
   logic [OUT_W-1:0]  r_tail;
   logic [OUT_W-1:0]  w_head_next;
   logic [OUT_W-1:0]  w_tail_next;
   logic [OUT_W-1:0]  w_decoded;
   logic [OUT_W-1:0]  w_zero_word;
   logic              r_in_ready;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;
   logic              w_out_valid;

   // Index 0 either selects bit 0 or aliases to "nothing selected" like the encoder
   generate
      if (ZERO_MAPS_BIT0) begin : g_zero_bit0
         assign w_zero_word = {{(OUT_W-1){1'b0}}, 1'b1};
      end else begin : g_zero_none
         assign w_zero_word = '0;
      end
   endgenerate

   always_comb begin
      w_decoded = '0;
      if (bus.in_enable) begin
         if (bus.in_index == '0) begin
            w_decoded = w_zero_word;
         end else begin
            w_decoded[bus.in_index] = 1'b1;
         end
      end
   end

   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_push      = bus.in_valid & r_in_ready;
   assign w_pop       = w_out_valid & bus.out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_head     <= '0;
         r_tail     <= '0;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_head     <= w_head_next;
         r_tail     <= w_tail_next;
         r_in_ready <= (w_state_next != ST_TWO);
      end
   end

   // Head is the word on the output; tail only holds the second word in TWO
   always_comb begin
      w_state_next = r_state;
      w_head_next  = r_head;
      w_tail_next  = r_tail;
      case (r_state)
         ST_EMPTY: begin
            if (w_push) begin
               w_head_next  = w_decoded;
               w_state_next = ST_ONE;
            end
         end
         ST_ONE: begin
            case ({w_push, w_pop})
               2'b11: w_head_next = w_decoded;
               2'b10: begin
                  w_tail_next  = w_decoded;
                  w_state_next = ST_TWO;
               end
               2'b01: w_state_next = ST_EMPTY;
               default: w_state_next = ST_ONE;
            endcase
         end
         ST_TWO: begin
            if (w_pop) begin
               w_head_next  = r_tail;
               w_state_next = ST_ONE;
            end
         end
         default: w_state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (bus.clr_count) begin
         r_count <= '0;
      end else if (w_pop && (r_count != c_CNT_MAX)) begin
         r_count <= r_count + c_CNT_ONE;
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_onehot = w_out_valid ? r_head : '0;
   assign bus.out_count  = r_count;

   a_onehot_popcount: assert property (@(posedge clk) $countones(bus.out_onehot) <= 1)
      else $error("out_onehot has more than one bit set");

   a_no_ready_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      (r_state == ST_TWO) |-> !r_in_ready)
      else $error("in_ready high while buffer full");
endmodule
`default_nettype wire

// File: tb/tb_decoder_4_16_stream.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_decoder_4_16_stream : two decoder configurations, one stimulus |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_decoder_4_16_stream;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] in_index;
   logic       in_enable;
   logic       out_ready;
   logic       clr_count;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   // Configuration A: bit0 for index 0, 16-bit counter. B: zero word, 3-bit counter.
   decoder_4_16_stream_if #(.IDX_W(4), .CNT_W(16)) bus_a ();
   decoder_4_16_stream_if #(.IDX_W(4), .CNT_W(3))  bus_b ();

   decoder_4_16_stream #(.IDX_W(4), .CNT_W(16), .ZERO_MAPS_BIT0(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
   decoder_4_16_stream #(.IDX_W(4), .CNT_W(3), .ZERO_MAPS_BIT0(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   assign bus_a.in_valid  = in_valid;
   assign bus_a.in_index  = in_index;
   assign bus_a.in_enable = in_enable;
   assign bus_a.out_ready = out_ready;
   assign bus_a.clr_count = clr_count;
   assign bus_b.in_valid  = in_valid;
   assign bus_b.in_index  = in_index;
   assign bus_b.in_enable = in_enable;
   assign bus_b.out_ready = out_ready;
   assign bus_b.clr_count = clr_count;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [15:0] f_word(logic [3:0] idx, logic en, bit zmb);
      if (!en) return 16'h0000;
      if (idx == 4'd0) return zmb ? 16'h0001 : 16'h0000;
      return 16'h0001 << idx;
   endfunction

   // Reference model: a FIFO of expected words, capacity 2, updated on each edge
   logic [15:0] q_a[$];
   logic [15:0] q_b[$];
   int          m_cnt_a = 0;
   int          m_cnt_b = 0;
   bit          m_ready = 1'b0;

   always @(posedge clk) begin
      bit push;
      bit pop;
      if (!rst_n) begin
         q_a.delete();
         q_b.delete();
         m_cnt_a = 0;
         m_cnt_b = 0;
         m_ready = 1'b0;
      end else begin
         push = in_valid && m_ready;
         pop  = (q_a.size() > 0) && out_ready;
         if (pop) begin
            void'(q_a.pop_front());
            void'(q_b.pop_front());
         end
         if (clr_count) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
         end else if (pop) begin
            if (m_cnt_a < 65535) m_cnt_a++;
            if (m_cnt_b < 7)     m_cnt_b++;
         end
         if (push) begin
            q_a.push_back(f_word(in_index, in_enable, 1'b1));
            q_b.push_back(f_word(in_index, in_enable, 1'b0));
         end
         m_ready = (q_a.size() < 2);
      end
   end

   // Per-cycle comparison plus a log of words actually transferred out
   logic [15:0] obs_a[$];
   logic [15:0] obs_b[$];

   always @(negedge clk) begin
      if (check_en) begin
         check("a.in_ready",   bus_a.in_ready,   m_ready);
         check("b.in_ready",   bus_b.in_ready,   m_ready);
         check("a.out_valid",  bus_a.out_valid,  q_a.size() > 0);
         check("b.out_valid",  bus_b.out_valid,  q_b.size() > 0);
         check("a.out_onehot", bus_a.out_onehot, (q_a.size() > 0) ? q_a[0] : 16'h0);
         check("b.out_onehot", bus_b.out_onehot, (q_b.size() > 0) ? q_b[0] : 16'h0);
         check("a.out_count",  bus_a.out_count,  m_cnt_a);
         check("b.out_count",  bus_b.out_count,  m_cnt_b);
         if (bus_a.out_valid && out_ready) obs_a.push_back(bus_a.out_onehot);
         if (bus_b.out_valid && out_ready) obs_b.push_back(bus_b.out_onehot);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; in_index = 4'd0; in_enable = 1'b0;
      out_ready = 1'b0; clr_count = 1'b0;
      step();
      rst_n = 1'b1;
      obs_a.delete();
      obs_b.delete();
   endtask

   // Holds the index on the bus until it is accepted; leaves in_valid high
   task automatic push(input logic [3:0] idx, input logic en);
      bit acc = 1'b0;
      in_valid = 1'b1; in_index = idx; in_enable = en;
      for (int t = 0; t < 20 && !acc; t++) begin
         acc = bus_a.in_ready;
         step();
      end
      check("push_accept", acc, 1'b1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      int base;
      int n_acc;
      bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

      // Reset state
      apply_reset();
      check_en = 1'b1;
      check("rst.out_valid",  bus_a.out_valid,  1'b0);
      check("rst.in_ready",   bus_a.in_ready,   1'b0);
      check("rst.out_count",  bus_a.out_count,  16'd0);
      step();
      check("rst.ready_next", bus_a.in_ready,   1'b1);

      // Full sweep at full throughput
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) push(i[3:0], 1'b1);
      idle(3);
      check("sweep.n_words", obs_a.size(), 16);
      check("sweep.first",   obs_a[0],  16'h0001);
      check("sweep.idx5",    obs_a[5],  16'h0020);
      check("sweep.last",    obs_a[15], 16'h8000);
      check("sweep.count",   bus_a.out_count, 16'd16);

      // Disabled transfer and index 0 aliasing
      apply_reset();
      out_ready = 1'b1;
      push(4'd7, 1'b0);
      push(4'd0, 1'b1);
      idle(3);
      check("zero.b_w0",   obs_b[0], 16'h0000);
      check("zero.b_w1",   obs_b[1], 16'h0000);
      check("zero.a_w1",   obs_a[1], 16'h0001);
      check("zero.b_cnt",  bus_b.out_count, 3'd2);

      // Backpressure: third index held while buffer full
      apply_reset();
      out_ready = 1'b0;
      push(4'd5, 1'b1);
      push(4'd9, 1'b1);
      in_valid = 1'b1; in_index = 4'd3; in_enable = 1'b1;
      repeat (3) step();
      check("bp.in_ready", bus_a.in_ready,   1'b0);
      check("bp.head",     bus_a.out_onehot, 16'h0020);
      out_ready = 1'b1;
      push(4'd3, 1'b1);
      idle(4);
      check("bp.w0", obs_a[0], 16'h0020);
      check("bp.w1", obs_a[1], 16'h0200);
      check("bp.w2", obs_a[2], 16'h0008);

      // Simultaneous push/pop with out_ready pattern 1,0,1,1
      base = obs_a.size();
      n_acc = 0;
      for (int c = 0; c < 24; c++) begin
         out_ready = pat[c % 4];
         in_valid = 1'b1;
         in_index = 4'($urandom_range(0, 15));
         in_enable = 1'b1;
         if (bus_a.in_ready) n_acc++;
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      check("alt.no_loss", obs_a.size() - base, n_acc);

      // Reset while buffer holds two words
      out_ready = 1'b0;
      push(4'd1, 1'b1);
      push(4'd2, 1'b1);
      in_valid = 1'b0;
      check("mid.full", bus_a.in_ready, 1'b0);
      apply_reset();
      check("mid.out_valid",  bus_a.out_valid,  1'b0);
      check("mid.out_onehot", bus_a.out_onehot, 16'h0);
      check("mid.out_count",  bus_a.out_count,  16'd0);
      check("mid.in_ready",   bus_a.in_ready,   1'b0);
      step();
      check("mid.ready_next", bus_a.in_ready,   1'b1);

      // Counter saturation and clear priority
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) push(4'(i + 1), 1'b1);
      idle(3);
      check("sat.b_cnt", bus_b.out_count, 3'd7);
      check("sat.a_cnt", bus_a.out_count, 16'd10);
      push(4'd4, 1'b1);
      in_valid = 1'b0;
      clr_count = 1'b1;
      check("clr.pending", bus_a.out_valid, 1'b1);
      step();
      clr_count = 1'b0;
      check("clr.b_cnt", bus_b.out_count, 3'd0);
      check("clr.a_cnt", bus_a.out_count, 16'd0);

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_index  = 4'($urandom_range(0, 15));
         in_enable = ($urandom_range(0, 4) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         clr_count = ($urandom_range(0, 31) == 0);
         step();
      end
      in_valid = 1'b0;
      clr_count = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
